// File: rtl/div_chain_ctrl.sv
// -----------------------------------------------------------------------------
// div_chain_ctrl
//
// Controller for a two-stage cascaded clock-enable divider. Stage 0 divides
// clk by div0 and produces tick0. Stage 1 divides tick0 pulses by div1 and
// produces tick1. Both ticks are registered single-cycle enables, so all
// downstream logic stays on clk. A run can be continuous (burst = 0) or can
// stop by itself after a finite number of tick1 pulses.
//
// Handshakes (valid/ready):
//   Configuration transfers on a rising edge where cfg_valid & cfg_ready are
//   both high. cfg_ready is high only in IDLE. The offerer may hold cfg_valid
//   for any number of cycles and must keep cfg_div0/cfg_div1/cfg_burst stable
//   while it is high. start and stop are level-sampled commands. start is
//   honoured only in IDLE, and stop is honoured only in RUN.
//
// Ports:
//   clk        system clock; all logic on the rising edge
//   rst        synchronous, active-high reset
//   cfg_valid  configuration offered
//   cfg_ready  configuration can be accepted (IDLE only)
//   cfg_div0   stage-0 divisor (clk cycles per tick0); 0 is stored as 1
//   cfg_div1   stage-1 divisor (tick0 pulses per tick1); 0 is stored as 1
//   cfg_burst  number of tick1 pulses to run; 0 = continuous
//   start      begin a run
//   stop       abort a run
//   busy       high while a run is active (including the completion cycle)
//   tick0      registered 1-cycle stage-0 enable
//   tick1      registered 1-cycle stage-1 enable
//   out        out[0] toggles on each tick0; out[1] toggles on each tick1
//   done       1-cycle pulse on the final tick1 of a finite burst
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
// -----------------------------------------------------------------------------
module div_chain_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div0,
   input  logic [CNT_W-1:0] cfg_div1,
   input  logic [CNT_W-1:0] cfg_burst,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             tick0,
   output logic             tick1,
   output logic [1:0]       out,
   output logic             done,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2   // cycle carrying the final tick1/done; then IDLE
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt0_q, cnt1_q, bcnt_q;
   logic [CNT_W-1:0] div0_q, div1_q, burst_q;
   logic             tick0_q, tick1_q, done_q, busy_q, cfg_ready_q;
   logic [1:0]       out_q;

   // Next values of the registered tick/done outputs while counting. A stop
   // in RUN suppresses every event on that edge, so stop beats a final tick1.
   logic tick0_d, tick1_d, done_d;

   always_comb begin
      tick0_d = (state_q == S_RUN) && !stop && (cnt0_q == div0_q - ONE);
      tick1_d = tick0_d && (cnt1_q == div1_q - ONE);
      done_d  = tick1_d && (burst_q != '0) && (bcnt_q == burst_q - ONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
         bcnt_q      <= '0;
         div0_q      <= ONE;
         div1_q      <= ONE;
         burst_q     <= '0;
         tick0_q     <= 1'b0;
         tick1_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
         out_q       <= 2'b00;
      end else begin
         tick0_q <= tick0_d;
         tick1_q <= tick1_d;
         done_q  <= done_d;
         case (state_q)
            S_IDLE: begin
               // Capture before start is looked at, so a simultaneous
               // config+start runs with the new values.
               if (cfg_valid) begin
                  div0_q  <= (cfg_div0 == '0) ? ONE : cfg_div0;
                  div1_q  <= (cfg_div1 == '0) ? ONE : cfg_div1;
                  burst_q <= cfg_burst;
               end
               cnt0_q <= '0;
               cnt1_q <= '0;
               bcnt_q <= '0;
               if (start) begin
                  state_q     <= S_RUN;
                  busy_q      <= 1'b1;
                  cfg_ready_q <= 1'b0;
               end
            end
            S_RUN: begin
               if (stop) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  cfg_ready_q <= 1'b1;
                  cnt0_q      <= '0;
                  cnt1_q      <= '0;
                  bcnt_q      <= '0;
               end else begin
                  cnt0_q <= tick0_d ? '0 : cnt0_q + ONE;
                  if (tick0_d) begin
                     out_q[0] <= ~out_q[0];
                     cnt1_q   <= tick1_d ? '0 : cnt1_q + ONE;
                  end
                  if (tick1_d) begin
                     out_q[1] <= ~out_q[1];
                     // Continuous runs never count bursts, so bcnt cannot wrap.
                     if (burst_q != '0) bcnt_q <= bcnt_q + ONE;
                  end
                  if (done_d) begin
                     state_q <= S_DONE;
                     bcnt_q  <= '0;
                  end
               end
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               cfg_ready_q <= 1'b1;
               cnt0_q      <= '0;
               cnt1_q      <= '0;
               bcnt_q      <= '0;
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               cfg_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign busy      = busy_q;
   assign tick0     = tick0_q;
   assign tick1     = tick1_q;
   assign done      = done_q;
   assign out       = out_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_div_chain_ctrl.sv
module tb_div_chain_ctrl;
  localparam int W = 8;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cfg_valid, cfg_ready, start, stop, busy, tick0, tick1, done;
  logic [W-1:0] cfg_div0, cfg_div1, cfg_burst;
  logic [1:0] out, dbg_state;

  div_chain_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div0(cfg_div0), .cfg_div1(cfg_div1), .cfg_burst(cfg_burst),
    .start(start), .stop(stop), .busy(busy), .tick0(tick0), .tick1(tick1),
    .out(out), .done(done), .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural model ----------------
  // A run is described by k = edges elapsed since the start edge. Tick
  // positions follow from plain division of k by the stored divisors.
  int m_div0 = 1, m_div1 = 1, m_burst = 0, m_k = 0;
  bit m_run = 0, m_fin = 0;
  logic [1:0] m_out = 2'b00;
  logic e_ready = 1'b1, e_busy = 1'b0, e_t0 = 1'b0, e_t1 = 1'b0, e_done = 1'b0;

  task automatic model_step();
    int n0, n1;
    e_t0 = 0; e_t1 = 0; e_done = 0;
    if (rst) begin
      m_run = 0; m_fin = 0; m_out = 2'b00;
      m_div0 = 1; m_div1 = 1; m_burst = 0; e_busy = 0;
    end else if (m_fin) begin
      m_fin = 0; e_busy = 0;
    end else if (!m_run) begin
      if (cfg_valid) begin
        m_div0  = (cfg_div0 == 0) ? 1 : int'(cfg_div0);
        m_div1  = (cfg_div1 == 0) ? 1 : int'(cfg_div1);
        m_burst = int'(cfg_burst);
      end
      if (start) begin
        m_run = 1; m_k = 0; e_busy = 1;
      end
    end else if (stop) begin
      m_run = 0; e_busy = 0;
    end else begin
      m_k++;
      n0 = m_k / m_div0;
      n1 = n0 / m_div1;
      e_t0 = (m_k % m_div0) == 0;
      e_t1 = e_t0 && ((n0 % m_div1) == 0);
      e_done = e_t1 && (m_burst != 0) && (n1 == m_burst);
      if (e_t0) m_out[0] = ~m_out[0];
      if (e_t1) m_out[1] = ~m_out[1];
      if (e_done) begin m_run = 0; m_fin = 1; end
    end
    e_ready = !(m_run || m_fin);
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare point: model advances one edge, DUT is sampled #1 later.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("ready_busy_t0_t1_done_out", {cfg_ready, busy, tick0, tick1, done, out},
          {e_ready, e_busy, e_t0, e_t1, e_done, m_out});
  endtask

  // ---------------- driver tasks ----------------
  task automatic quiet();
    rst = 0; cfg_valid = 0; start = 0; stop = 0;
  endtask

  task automatic configure(input int d0, input int d1, input int b, input bit with_start);
    cfg_valid = 1; cfg_div0 = W'(d0); cfg_div1 = W'(d1); cfg_burst = W'(b);
    start = with_start;
    step();
    quiet();
  endtask

  task automatic do_start();
    start = 1; step(); quiet();
  endtask

  task automatic do_stop();
    stop = 1; step(); quiet();
  endtask

  // Runs n edges after the start edge; returns the number of tick0 pulses.
  task automatic count_ticks(input int n, output int t0s);
    t0s = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tick0) t0s++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0s, both, dones, done_at, fall_at;
    logic [1:0] held;
    logic [7:0] got[$];

    quiet();
    cfg_div0 = '0; cfg_div1 = '0; cfg_burst = '0;
    rst = 1;
    step(); step();
    check("reset_ready", cfg_ready, 1);
    check("reset_out", out, 0);
    quiet();
    step();

    // Case 1: div0=3, div1=2, burst=2, start one cycle after config.
    configure(3, 2, 2, 0);
    do_start();
    exp_q = '{8'd3, 8'd6, 8'd9, 8'd12};
    got.delete();
    done_at = -1; fall_at = -1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (tick0) got.push_back(8'(i));
      if (done && done_at < 0) done_at = i;
      if (!busy && fall_at < 0) fall_at = i;
    end
    check("c1_tick0_count", got.size(), 4);
    while (exp_q.size() > 0 && got.size() > 0) check("c1_tick0_pos", got.pop_front(), exp_q.pop_front());
    check("c1_done_at", done_at, 12);
    check("c1_busy_fall", fall_at, 13);
    check("c1_out_final", out, 2'b00);

    // Case 2: div0=0 -> 1, div1=1, burst=3, config with start.
    configure(0, 1, 3, 1);
    both = 0; dones = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (tick0 && tick1) both++;
      if (done) begin dones++; check("c2_done_on_third", i, 3); end
    end
    check("c2_tick_cycles", both, 3);
    check("c2_done_count", dones, 1);
    check("c2_out_final", out, 2'b11);

    // Case 3: continuous, div0=4, then stop at an arbitrary cycle.
    configure(4, 1, 0, 1);
    count_ticks(100, t0s);
    check("c3_ticks_100", t0s, 25);
    for (int i = 0; i < int'($urandom_range(1, 9)); i++) step();
    held = out;
    do_stop();
    check("c3_stop_busy", busy, 0);
    count_ticks(8, t0s);
    check("c3_no_ticks_after_stop", t0s, 0);
    check("c3_out_held", out, held);

    // Case 4: config is ignored in RUN; new divisor only when re-offered.
    configure(2, 1, 0, 1);
    cfg_valid = 1; cfg_div0 = 8'd7; cfg_div1 = 8'd1; cfg_burst = 8'd0;
    t0s = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick0) t0s++;
      check("c4_ready_low_in_run", cfg_ready, 0);
    end
    check("c4_period_kept", t0s, 10);
    quiet();
    do_stop();
    do_start();
    count_ticks(14, t0s);
    check("c4_old_div_reused", t0s, 7);
    do_stop();
    configure(7, 1, 0, 1);
    count_ticks(14, t0s);
    check("c4_new_div_used", t0s, 2);
    do_stop();

    // Case 5: stop on the edge that would give the final tick1.
    configure(2, 1, 2, 1);
    step(); step(); step();
    stop = 1;
    step();
    quiet();
    check("c5_no_done", done, 0);
    check("c5_no_tick1", tick1, 0);
    check("c5_busy_low", busy, 0);

    // Case 6: reset in the middle of a run.
    configure(5, 1, 0, 1);
    for (int i = 0; i < 12; i++) step();
    rst = 1;
    step();
    quiet();
    check("c6_out_zero", out, 0);
    check("c6_ticks_zero", {tick0, tick1, done, busy}, 0);
    check("c6_ready", cfg_ready, 1);
    check("c6_state_idle", dbg_state, 0);

    // Randomised traffic checked cycle by cycle against the model.
    for (int r = 0; r < 10; r++) begin
      configure($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1));
      for (int i = 0; i < 60; i++) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_div0  = W'($urandom_range(0, 5));
        cfg_div1  = W'($urandom_range(0, 3));
        cfg_burst = W'($urandom_range(0, 3));
        start     = ($urandom_range(0, 7) == 0);
        stop      = ($urandom_range(0, 39) == 0);
        step();
      end
      quiet();
      stop = 1; step(); quiet(); step(); step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
